sort_engine: RTL and testbench

- Parametrised iterative sorter for one vector of N unsigned W-bit keys, sorted ascending or descending per job.
- Uses odd-even transposition: N/2 compare-exchanges per cycle.
- Exits early once the vector is sorted.
- Returns the sorted vector plus the original index of every output element (argsort). Sits between stream producers and consumers behind valid/ready handshakes.

---
 rtl/sort_pkg.sv | 43 ++++
 rtl/sort_cmp_swap.sv | 36 +++
 rtl/sort_engine.sv | 198 +++++++++++++++++++
 tb/tb_sort_engine.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared FSM encodings and bus packing helpers for sort_engine
//
// Purpose: state constants for the sort FSM and helpers that extract or place
// element k of a packed bus where element 0 sits at the most significant end.
// Helpers work on a fixed maximum bus width; callers size-cast in and out.
package sort_pkg;

  typedef logic [1:0] sort_state_t;

  localparam sort_state_t ST_IDLE = 2'd0;
  localparam sort_state_t ST_SORT = 2'd1;
  localparam sort_state_t ST_DONE = 2'd2;

  // Largest supported bus (64 keys x 32 bits) and element width.
  localparam int unsigned SORT_BUS_MAX  = 2048;
  localparam int unsigned SORT_ELEM_MAX = 32;

  // Element k of an n-element, w-bit-per-element bus, element 0 at MSB.
  function automatic logic [SORT_ELEM_MAX-1:0] bus_get(
    input logic [SORT_BUS_MAX-1:0] bus,
    input int unsigned             n,
    input int unsigned             w,
    input int unsigned             k
  );
    logic [SORT_BUS_MAX-1:0]  shifted;
    logic [SORT_ELEM_MAX-1:0] mask;
    shifted = bus >> ((n - 1 - k) * w);
    // For w == 32 the shift yields 0 and the subtraction wraps to all ones.
    mask = (SORT_ELEM_MAX'(1) << w) - SORT_ELEM_MAX'(1);
    return shifted[SORT_ELEM_MAX-1:0] & mask;
  endfunction

  // Bus with only element k set to val; OR the results together to pack.
  function automatic logic [SORT_BUS_MAX-1:0] bus_place(
    input logic [SORT_ELEM_MAX-1:0] val,
    input int unsigned              n,
    input int unsigned              w,
    input int unsigned              k
  );
    return SORT_BUS_MAX'(val) << ((n - 1 - k) * w);
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// rtl/sort_cmp_swap.sv - combinational compare-exchange cell with index carry
//
// Purpose: orders one adjacent key pair for the requested direction and moves
// the original indices along with the keys. Equal keys never swap.
// Ports:
//   desc_i              1 = descending order, 0 = ascending
//   key_a_i, key_b_i    keys at positions a and a+1
//   idx_a_i, idx_b_i    original indices carried with the keys
//   key_lo_o, idx_lo_o  element that belongs at position a
//   key_hi_o, idx_hi_o  element that belongs at position a+1
//   swapped_o           the pair was out of order and exchanged
module sort_cmp_swap #(
  parameter int W  = 8,
  parameter int IW = 4
) (
  input  logic          desc_i,
  input  logic [W-1:0]  key_a_i,
  input  logic [W-1:0]  key_b_i,
  input  logic [IW-1:0] idx_a_i,
  input  logic [IW-1:0] idx_b_i,
  output logic [W-1:0]  key_lo_o,
  output logic [W-1:0]  key_hi_o,
  output logic [IW-1:0] idx_lo_o,
  output logic [IW-1:0] idx_hi_o,
  output logic          swapped_o
);

  // Strict comparison keeps equal keys in place, which makes the sort stable.
  assign swapped_o = desc_i ? (key_a_i < key_b_i) : (key_a_i > key_b_i);

  assign key_lo_o = swapped_o ? key_b_i : key_a_i;
  assign key_hi_o = swapped_o ? key_a_i : key_b_i;
  assign idx_lo_o = swapped_o ? idx_b_i : idx_a_i;
  assign idx_hi_o = swapped_o ? idx_a_i : idx_b_i;

endmodule

// File: rtl/sort_engine.sv
// rtl/sort_engine.sv - iterative odd-even transposition sorter with argsort
//
// Purpose: accepts one vector of N unsigned W-bit keys, sorts it ascending or
// descending with one odd-even transposition phase per cycle, stops early once
// two consecutive phases make no swap, and returns keys plus original indices.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   in_valid      job offered           in_ready   engine idle, accepts job
//   in_data       N*W keys, elem 0 MSB  in_desc    1 = descending
//   out_valid     result held           out_ready  consumer accepts
//   out_data      sorted keys           out_idx    original index per element
//   out_phases    phases executed       busy       state is not IDLE
module sort_engine
  import sort_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int W  = 8,
  localparam int IW = $clog2(N),
  localparam int PW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic          in_desc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N*IW-1:0] out_idx,
  output logic [PW-1:0]   out_phases,
  output logic          busy
);

  localparam int DW  = N * W;
  localparam int XW  = N * IW;
  localparam int NL  = N / 2;

  sort_state_t   state_q, state_d;
  logic [W-1:0]  key_q [N];
  logic [W-1:0]  key_d [N];
  logic [IW-1:0] idx_q [N];
  logic [IW-1:0] idx_d [N];
  logic          desc_q, desc_d;
  logic [PW-1:0] p_q, p_d;
  logic          prev_swap_q, prev_swap_d;

  // Compare-exchange lanes, shared by even and odd phases.
  logic [W-1:0]  ca_key [NL];
  logic [W-1:0]  cb_key [NL];
  logic [IW-1:0] ca_idx [NL];
  logic [IW-1:0] cb_idx [NL];
  logic [W-1:0]  lo_key [NL];
  logic [W-1:0]  hi_key [NL];
  logic [IW-1:0] lo_idx [NL];
  logic [IW-1:0] hi_idx [NL];
  logic [NL-1:0] lane_swapped;
  logic [NL-1:0] lane_live;
  logic          any_swap;

  logic [W-1:0]  key_n [N];
  logic [IW-1:0] idx_n [N];

  // Lane i handles (2i, 2i+1) on even phases and (2i+1, 2i+2) on odd ones.
  // The top lane has no odd pair; it is fed a dummy pair and masked off.
  for (genvar i = 0; i < NL; i++) begin : g_lane
    localparam int EA = 2 * i;
    localparam int EB = 2 * i + 1;
    localparam int OA = 2 * i + 1;
    localparam int OB = (2 * i + 2 < N) ? 2 * i + 2 : 2 * i + 1;

    assign ca_key[i]    = p_q[0] ? key_q[OA] : key_q[EA];
    assign cb_key[i]    = p_q[0] ? key_q[OB] : key_q[EB];
    assign ca_idx[i]    = p_q[0] ? idx_q[OA] : idx_q[EA];
    assign cb_idx[i]    = p_q[0] ? idx_q[OB] : idx_q[EB];
    assign lane_live[i] = !p_q[0] || (OB != OA);

    sort_cmp_swap #(
      .W  (W),
      .IW (IW)
    ) u_cmp (
      .desc_i    (desc_q),
      .key_a_i   (ca_key[i]),
      .key_b_i   (cb_key[i]),
      .idx_a_i   (ca_idx[i]),
      .idx_b_i   (cb_idx[i]),
      .key_lo_o  (lo_key[i]),
      .key_hi_o  (hi_key[i]),
      .idx_lo_o  (lo_idx[i]),
      .idx_hi_o  (hi_idx[i]),
      .swapped_o (lane_swapped[i])
    );
  end

  assign any_swap = |(lane_swapped & lane_live);

  // Vector after the current phase.
  always_comb begin
    key_n = key_q;
    idx_n = idx_q;
    if (!p_q[0]) begin
      for (int i = 0; i < NL; i++) begin
        key_n[2*i]   = lo_key[i];
        key_n[2*i+1] = hi_key[i];
        idx_n[2*i]   = lo_idx[i];
        idx_n[2*i+1] = hi_idx[i];
      end
    end else begin
      for (int i = 0; i < NL - 1; i++) begin
        key_n[2*i+1] = lo_key[i];
        key_n[2*i+2] = hi_key[i];
        idx_n[2*i+1] = lo_idx[i];
        idx_n[2*i+2] = hi_idx[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    idx_d       = idx_q;
    desc_d      = desc_q;
    p_d         = p_q;
    prev_swap_d = prev_swap_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < N; k++) begin
            key_d[k] = W'(bus_get(SORT_BUS_MAX'(in_data), N, W, k));
            idx_d[k] = IW'(k);
          end
          desc_d      = in_desc;
          p_d         = '0;
          prev_swap_d = 1'b0;
          state_d     = ST_SORT;
        end
      end
      ST_SORT: begin
        key_d       = key_n;
        idx_d       = idx_n;
        p_d         = p_q + 1'b1;
        prev_swap_d = any_swap;
        // Two quiet phases in a row (one even, one odd) prove the vector
        // sorted; p_q != 0 ensures the previous phase really happened.
        if ((p_q == PW'(N - 1)) || (!any_swap && !prev_swap_q && (p_q != '0))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      desc_q      <= 1'b0;
      p_q         <= '0;
      prev_swap_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        key_q[k] <= '0;
        idx_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      desc_q      <= desc_d;
      p_q         <= p_d;
      prev_swap_q <= prev_swap_d;
      key_q       <= key_d;
      idx_q       <= idx_d;
    end
  end

  // Outputs come straight from the working registers, so they hold in DONE.
  logic [SORT_BUS_MAX-1:0] data_acc;
  logic [SORT_BUS_MAX-1:0] idx_acc;

  always_comb begin
    data_acc = '0;
    idx_acc  = '0;
    for (int k = 0; k < N; k++) begin
      data_acc = data_acc | bus_place(SORT_ELEM_MAX'(key_q[k]), N, W, k);
      idx_acc  = idx_acc  | bus_place(SORT_ELEM_MAX'(idx_q[k]), N, IW, k);
    end
  end

  assign out_data   = DW'(data_acc);
  assign out_idx    = XW'(idx_acc);
  assign out_phases = p_q;
  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sort_engine.sv
// tb/tb_sort_engine.sv - scoreboard testbench for sort_engine
module tb_sort_engine;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int IW = 4;
  localparam int PW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0]  in_data = '0;
  logic           in_desc = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [N*W-1:0]  out_data;
  logic [N*IW-1:0] out_idx;
  logic [PW-1:0]   out_phases;
  logic           busy;

  always #5 clk = ~clk;

  sort_engine #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_desc    (in_desc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_phases (out_phases),
    .busy       (busy)
  );

  typedef struct {
    logic [N*W-1:0]  data;
    logic [N*IW-1:0] idx;
    int              phases;   // -1: not hand-computed, skip phase/latency checks
    int              acc_cyc;
    string           name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   seen_valid = 0;

  localparam logic [N*W-1:0]  UP      = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [N*W-1:0]  DOWN    = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [N*W-1:0]  HIDESC  = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [N*W-1:0]  STAB_IN = 128'h5555555555AA55555555555555555555;
  localparam logic [N*W-1:0]  STAB_OUT= 128'hAA555555555555555555555555555555;
  localparam logic [N*W-1:0]  MIX_IN  = 128'h00070E050C030A01080F060D040B0209;
  localparam logic [N*IW-1:0] ID_FWD  = 64'h0123456789ABCDEF;
  localparam logic [N*IW-1:0] ID_REV  = 64'hFEDCBA9876543210;
  localparam logic [N*IW-1:0] ID_STAB = 64'h5012346789ABCDEF;
  localparam logic [N*IW-1:0] ID_MIX  = 64'h07E5C3A18F6D4B29;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard when the output handshake is presented.
  always @(negedge clk) begin
    if (rst) begin
      seen_valid = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        if (!seen_valid) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got out_data %0h expected no result", out_data);
        end
        seen_valid = !out_ready;
      end else begin
        if (!seen_valid && sb[0].phases >= 0)
          check({sb[0].name, "_latency"}, cyc - sb[0].acc_cyc, sb[0].phases);
        seen_valid = 1;
        if (out_ready) begin
          check({sb[0].name, "_data"}, out_data, sb[0].data);
          check({sb[0].name, "_idx"}, out_idx, sb[0].idx);
          if (sb[0].phases >= 0)
            check({sb[0].name, "_phases"}, out_phases, sb[0].phases);
          void'(sb.pop_front());
          seen_valid = 0;
        end
      end
    end
  end

  task automatic send(input string name, input logic [N*W-1:0] data, input logic desc,
                      input logic [N*W-1:0] exp_data, input logic [N*IW-1:0] exp_idx,
                      input int exp_phases);
    int   n;
    exp_t e;
    @(negedge clk);
    in_data  = data;
    in_desc  = desc;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready got 0 expected 1 within 100 cycles", name);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.data    = exp_data;
    e.idx     = exp_idx;
    e.phases  = exp_phases;
    e.acc_cyc = cyc;
    e.name    = name;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: pending got %0d expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation got stuck expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset state.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_phases", out_phases, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // 1: descending of ascending data, worst case.
    send("desc_rev", UP, 1'b1, DOWN, ID_REV, 16);
    drain("desc_rev");
    // 2: already descending, early exit.
    send("desc_sorted", HIDESC, 1'b1, HIDESC, ID_FWD, 2);
    drain("desc_sorted");
    // 3: stability with equal keys.
    send("stable", STAB_IN, 1'b1, STAB_OUT, ID_STAB, 7);
    drain("stable");
    // 4: ascending, sorted and reversed.
    send("asc_sorted", UP, 1'b0, UP, ID_FWD, 2);
    drain("asc_sorted");
    send("asc_rev", DOWN, 1'b0, UP, ID_REV, 16);
    drain("asc_rev");

    // 5: backpressure in DONE while in_valid toggles.
    out_ready = 1'b0;
    send("bp", UP, 1'b1, DOWN, ID_REV, 16);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_data  = {4{$urandom()}};
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, DOWN);
      check("bp_out_idx", out_idx, ID_REV);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    send("bp_next", MIX_IN, 1'b0, UP, ID_MIX, -1);
    drain("bp_next");

    // 6: asynchronous reset in the 4th SORT cycle.
    send("aborted", UP, 1'b1, DOWN, ID_REV, 16);
    repeat (3) @(posedge clk);
    #2;
    check("mid_busy", busy, 1);
    rst = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_idx", out_idx, 0);
    check("mid_rst_out_phases", out_phases, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    send("after_rst", UP, 1'b1, DOWN, ID_REV, 16);
    drain("after_rst");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
